tpu_tiled_ctrl: RTL

TPU_TILED_CTRL -- requirements
Module: tpu_tiled_ctrl

---
 rtl/tpu_tiled_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/tpu_tiled_ctrl.sv
// Tiled matrix-multiply controller: streams SA_DIM-wide operand groups from A/B into an
// SA_DIM x SA_DIM array, then writes (or accumulates) each result tile back to C row by row.
module tpu_tiled_ctrl #(
   parameter int SA_DIM = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int IDX_W  = 16,
   parameter int DIM_W  = 10
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   input  logic [DIM_W-1:0]                  K,
   input  logic [DIM_W-1:0]                  M,
   input  logic [DIM_W-1:0]                  N,
   input  logic                              acc_mode,
   input  logic signed [8:0]                 input_offset,
   output logic                              busy,
   output logic                              done,
   output logic [IDX_W-1:0]                  A_index,
   output logic [IDX_W-1:0]                  B_index,
   input  logic [SA_DIM*DATA_W-1:0]          A_data_out,
   input  logic [SA_DIM*DATA_W-1:0]          B_data_out,
   output logic                              C_wr_en,
   output logic [IDX_W-1:0]                  C_index,
   output logic [SA_DIM*ACC_W-1:0]           C_data_in,
   input  logic [SA_DIM*ACC_W-1:0]           C_data_out,
   output logic                              sa_in_valid,
   output logic                              sa_clear,
   output logic [SA_DIM*SA_DIM*DATA_W-1:0]   sa_row_in,
   output logic [SA_DIM*SA_DIM*DATA_W-1:0]   sa_col_in,
   input  logic [SA_DIM*SA_DIM*ACC_W-1:0]    sa_data_out,
   input  logic                              sa_busy
);

   localparam int RW = SA_DIM * DATA_W;
   localparam int CW = SA_DIM * ACC_W;
   localparam int JW = (SA_DIM > 1) ? $clog2(SA_DIM) : 1;
   localparam int EW = DIM_W + 2;

   typedef enum logic [3:0] {
      IDLE, CLR, CLR_WAIT, RD_ADDR, RD_DATA, SA_START, SA_WAIT, C_RD, C_WR, NEXT, DONE
   } state_t;

   state_t                     state;
   logic [DIM_W-1:0]           k_len, m_len, n_len, tr, tc;
   logic                       acc_q;
   logic [EW-1:0]              k_base;
   logic [JW-1:0]              j, row;
   logic [SA_DIM*RW-1:0]       a_buf, b_buf;
   logic [SA_DIM*CW-1:0]       c_buf;
   logic [IDX_W-1:0]           a_base, b_base, c_base;
   logic                       last_tr, last_tc;
   logic [CW-1:0]              c_row;

   // The offset is applied inside the array; the controller has no use for it.
   logic unused_offset;
   assign unused_offset = ^input_offset;

   assign a_base  = IDX_W'(tr) * IDX_W'(k_len);
   assign b_base  = IDX_W'(tc) * IDX_W'(k_len);
   assign c_base  = IDX_W'(tc) * IDX_W'(m_len) + IDX_W'(tr) * IDX_W'(SA_DIM);
   assign last_tr = (EW'(tr) + EW'(1)) * EW'(SA_DIM) >= EW'(m_len);
   assign last_tc = (EW'(tc) + EW'(1)) * EW'(SA_DIM) >= EW'(n_len);

   assign sa_row_in = a_buf;
   assign sa_col_in = b_buf;
   assign c_row     = c_buf[int'(row)*CW +: CW];

   for (genvar e = 0; e < SA_DIM; e++) begin : g_wdata
      assign C_data_in[e*ACC_W +: ACC_W] = !C_wr_en ? '0 :
         acc_q ? C_data_out[e*ACC_W +: ACC_W] + c_row[e*ACC_W +: ACC_W]
               : c_row[e*ACC_W +: ACC_W];
   end

   function automatic logic row_ok(input logic [JW-1:0] r);
      return EW'(tr) * EW'(SA_DIM) + EW'(r) < EW'(m_len);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: operand and result buffers are reset as well, so nothing from an aborted job
         // can leak onto the array or C ports afterwards.
         state       <= IDLE;
         k_len       <= '0;
         m_len       <= '0;
         n_len       <= '0;
         acc_q       <= 1'b0;
         tr          <= '0;
         tc          <= '0;
         k_base      <= '0;
         j           <= '0;
         row         <= '0;
         a_buf       <= '0;
         b_buf       <= '0;
         c_buf       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         A_index     <= '0;
         B_index     <= '0;
         C_wr_en     <= 1'b0;
         C_index     <= '0;
         sa_in_valid <= 1'b0;
         sa_clear    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               k_len  <= K;
               m_len  <= M;
               n_len  <= N;
               acc_q  <= acc_mode;
               busy   <= 1'b1;
               tr     <= '0;
               tc     <= '0;
               k_base <= '0;
               if (K == '0 || M == '0 || N == '0) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  sa_clear <= 1'b1;
                  state    <= CLR;
               end
            end
            CLR: begin
               sa_clear <= 1'b0;
               state    <= CLR_WAIT;
            end
            CLR_WAIT: if (!sa_busy) begin
               j       <= '0;
               A_index <= a_base + IDX_W'(k_base);
               B_index <= b_base + IDX_W'(k_base);
               state   <= RD_ADDR;
            end
            RD_ADDR: state <= RD_DATA;
            RD_DATA: begin
               // Slots past the end of K are zero so a partial group adds nothing.
               if (k_base + EW'(j) < EW'(k_len)) begin
                  a_buf[int'(j)*RW +: RW] <= A_data_out;
                  b_buf[int'(j)*RW +: RW] <= B_data_out;
               end else begin
                  a_buf[int'(j)*RW +: RW] <= '0;
                  b_buf[int'(j)*RW +: RW] <= '0;
               end
               if (j == JW'(SA_DIM - 1)) begin
                  sa_in_valid <= 1'b1;
                  state       <= SA_START;
               end else begin
                  j       <= j + JW'(1);
                  A_index <= A_index + IDX_W'(1);
                  B_index <= B_index + IDX_W'(1);
                  state   <= RD_ADDR;
               end
            end
            SA_START: begin
               sa_in_valid <= 1'b0;
               k_base      <= k_base + EW'(SA_DIM);
               state       <= SA_WAIT;
            end
            SA_WAIT: if (!sa_busy) begin
               c_buf <= sa_data_out;
               if (k_base < EW'(k_len)) begin
                  j       <= '0;
                  A_index <= a_base + IDX_W'(k_base);
                  B_index <= b_base + IDX_W'(k_base);
                  state   <= RD_ADDR;
               end else begin
                  row     <= '0;
                  C_index <= c_base;
                  if (acc_q) begin
                     state <= C_RD;
                  end else begin
                     C_wr_en <= row_ok('0);
                     state   <= C_WR;
                  end
               end
            end
            C_RD: begin
               C_wr_en <= row_ok(row);
               state   <= C_WR;
            end
            C_WR: begin
               if (row == JW'(SA_DIM - 1)) begin
                  C_wr_en <= 1'b0;
                  state   <= NEXT;
               end else begin
                  row     <= row + JW'(1);
                  C_index <= C_index + IDX_W'(1);
                  if (acc_q) begin
                     C_wr_en <= 1'b0;
                     state   <= C_RD;
                  end else begin
                     C_wr_en <= row_ok(row + JW'(1));
                  end
               end
            end
            NEXT: begin
               k_base <= '0;
               if (!last_tr) begin
                  tr       <= tr + DIM_W'(1);
                  sa_clear <= 1'b1;
                  state    <= CLR;
               end else if (!last_tc) begin
                  tr       <= '0;
                  tc       <= tc + DIM_W'(1);
                  sa_clear <= 1'b1;
                  state    <= CLR;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
